// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the hazard unit.
// Holds the MUL/DIV opcodes, the EX latency of a MUL/DIV, the hazard FSM
// state encoding and the packed bundle of pipeline control strobes.
package cpu_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned STALL_W  = 16;
    localparam int unsigned MD_CNT_W = 2;
    localparam int unsigned MD_LAT   = 4;

    localparam logic [OPC_W-1:0] OP_MUL = 4'hE;
    localparam logic [OPC_W-1:0] OP_DIV = 4'hF;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    // Pipeline control strobes driven by the hazard unit each cycle.
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic hazard;
        logic idex_hold;
        logic md_done;
        logic busy;
    } hz_ctrl_t;

    // True for the multi-cycle EX operations.
    function automatic logic is_md_op(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    in   clock, rising-edge active
//   rst_n  in   asynchronous active-low reset
//   inc    in   increment by one at the next edge (stops at all-ones)
//   clr    in   clear to zero at the next edge, wins over inc
//   count  out  registered count value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush and multi-cycle
// MUL/DIV stall sequencing, plus a saturating count of PC-hold cycles.
// Ports:
//   clk           in   pipeline clock, rising-edge active
//   reset         in   asynchronous active-low reset
//   id_RA1/id_RA2 in   source registers of the instruction in decode
//   ex_opcode     in   opcode in the ID/EX buffer
//   ex_RA1        in   destination register in the ID/EX buffer
//   ex_memRead    in   ID/EX buffer holds a load
//   branch_taken  in   branch resolved taken in EX this cycle
//   stat_clr      in   synchronous clear of stall_count
//   pc_hold, ifid_hold, ifid_flush, hazard, idex_hold, md_done, busy
//                 out  combinational pipeline controls for the next edge
//   stall_count   out  registered saturating count of pc_hold cycles
module hazard_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   id_RA1,
    input  logic [REG_W-1:0]   id_RA2,
    input  logic [OPC_W-1:0]   ex_opcode,
    input  logic [REG_W-1:0]   ex_RA1,
    input  logic               ex_memRead,
    input  logic               branch_taken,
    input  logic               stat_clr,
    output logic               pc_hold,
    output logic               ifid_hold,
    output logic               ifid_flush,
    output logic               hazard,
    output logic               idex_hold,
    output logic               md_done,
    output logic               busy,
    output logic [STALL_W-1:0] stall_count
);

    md_state_e           state_q;
    md_state_e           state_d;
    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;
    hz_ctrl_t            ctl;
    logic                load_use;

    // R0 is not special: a load to R0 still stalls a dependent reader.
    assign load_use = ex_memRead && ((ex_RA1 == id_RA1) || (ex_RA1 == id_RA2));

    // State and MUL/DIV countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next state and control strobes; everything is forced low during reset.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        ctl      = '0;

        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    // A taken branch redirects fetch, so it beats a stall.
                    if (branch_taken) begin
                        ctl.ifid_flush = 1'b1;
                        ctl.hazard     = 1'b1;
                    end else if (is_md_op(ex_opcode)) begin
                        // First EX cycle of MUL/DIV; MD_LAT-1 hold cycles total.
                        ctl.pc_hold   = 1'b1;
                        ctl.ifid_hold = 1'b1;
                        ctl.idex_hold = 1'b1;
                        md_cnt_d      = MD_CNT_W'(MD_LAT - 2);
                        state_d       = MD_WAIT;
                    end else if (load_use) begin
                        ctl.pc_hold   = 1'b1;
                        ctl.ifid_hold = 1'b1;
                        ctl.hazard    = 1'b1;
                    end
                end

                MD_WAIT: begin
                    ctl.busy = 1'b1;
                    if (md_cnt_q != '0) begin
                        ctl.pc_hold   = 1'b1;
                        ctl.ifid_hold = 1'b1;
                        ctl.idex_hold = 1'b1;
                        md_cnt_d      = md_cnt_q - MD_CNT_W'(1);
                    end else begin
                        // Last EX cycle: release holds; the same op must not re-enter.
                        ctl.md_done = 1'b1;
                        state_d     = IDLE;
                    end
                end

                default: begin
                    state_d  = IDLE;
                    md_cnt_d = '0;
                end
            endcase
        end
    end

    assign pc_hold    = ctl.pc_hold;
    assign ifid_hold  = ctl.ifid_hold;
    assign ifid_flush = ctl.ifid_flush;
    assign hazard     = ctl.hazard;
    assign idex_hold  = ctl.idex_hold;
    assign md_done    = ctl.md_done;
    assign busy       = ctl.busy;

    // Counts every edge at which the PC is held.
    sat_counter #(
        .W (STALL_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (ctl.pc_hold),
        .clr   (stat_clr),
        .count (stall_count)
    );

endmodule : hazard_unit

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock, rising-edge active.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 id_RA1  in  4  first source register of the instruction in decode.
REQ-005 id_RA2  in  4  second source register of the instruction in decode.
REQ-006 ex_opcode  in  4  opcode held in the ID/EX buffer.
REQ-007 ex_RA1  in  4  destination register held in the ID/EX buffer.
REQ-008 ex_memRead  in  1  ID/EX buffer holds a load.
REQ-009 branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 stat_clr  in  1  synchronous clear of stall_count.
REQ-011 pc_hold  out  1  PC keeps its value at the next edge.
REQ-012 ifid_hold  out  1  IF/ID buffer keeps its contents at the next edge.
REQ-013 ifid_flush  out  1  IF/ID buffer loads a bubble at the next edge.
REQ-014 hazard  out  1  ID/EX buffer loads all-zero bubble at the next edge.
REQ-015 idex_hold  out  1  ID/EX buffer keeps its contents at the next edge.
REQ-016 md_done  out  1  last EX cycle of a MUL/DIV; ALU latches its result.
REQ-017 busy  out  1  FSM in MD_WAIT.
REQ-018 stall_count  out  16  saturating count of cycles with pc_hold=1.

Function
REQ-019 The FSM SHALL have two states: IDLE and MD_WAIT, plus a 2-bit down-counter md_cnt.
REQ-020 pc_hold, ifid_hold, ifid_flush, hazard, idex_hold, md_done and busy SHALL be combinational from state, md_cnt and inputs; state, md_cnt and stall_count are registered.
REQ-021 Load-use, IDLE: ex_memRead=1 and (ex_RA1==id_RA1 or ex_RA1==id_RA2) -> pc_hold=1, ifid_hold=1, hazard=1 for that cycle only; R0 is compared like any register.
REQ-022 Branch, IDLE: branch_taken=1 -> ifid_flush=1, hazard=1, pc_hold=0, ifid_hold=0; branch overrides a simultaneous load-use.
REQ-023 MUL/DIV entry, IDLE: ex_opcode is OP_MUL or OP_DIV -> pc_hold=ifid_hold=idex_hold=1, hazard=0, md_cnt<=MD_LAT-2, next state MD_WAIT.
REQ-024 MD_WAIT with md_cnt!=0: pc_hold=ifid_hold=idex_hold=1, md_cnt decrements.
REQ-025 MD_WAIT with md_cnt==0: all holds 0, md_done=1, next state IDLE; no re-entry, even though ex_opcode is still MUL/DIV that cycle.
REQ-026 A MUL/DIV SHALL occupy EX for exactly MD_LAT=4 cycles, with 3 hold cycles.
REQ-027 In MD_WAIT, branch_taken and load-use conditions SHALL be ignored.
REQ-028 With no condition active, all control outputs SHALL be 0.
REQ-029 stall_count SHALL increment by 1 on every edge where pc_hold=1, saturate at 16'hFFFF, and clear to 0 when stat_clr=1; clear has priority over increment.

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, md_cnt=0 and stall_count=0; all outputs read 0 while reset is low, including mid-MD_WAIT.
REQ-031 After reset release, detection SHALL resume on the first rising edge with no residual hold.

Structure
REQ-032 The shared package cpu_pkg SHALL hold OP_MUL=4'hE, OP_DIV=4'hF, MD_LAT=4, and the state encoding (IDLE=0, MD_WAIT=1).
REQ-033 stall_count SHALL be implemented in the sub-module sat_counter (16-bit, inc/clr inputs), instantiated once.

Verification
REQ-034 Load-use: ex_memRead=1, ex_RA1=3, id_RA2=3 -> pc_hold=ifid_hold=hazard=1 for one cycle; stall_count 0->1.
REQ-035 No dependency: ex_memRead=1, ex_RA1=3, id_RA1=4, id_RA2=5 -> all outputs 0.
REQ-036 MUL: ex_opcode=4'hE held -> holds high cycles 0-2, md_done=1 in cycle 3, busy=1 in cycles 1-3, back to IDLE, stall_count=3.
REQ-037 Branch with load-use: branch_taken=1, ex_memRead=1, ex_RA1=id_RA1=2 -> ifid_flush=hazard=1, pc_hold=0.
REQ-038 Reset mid-MD_WAIT: assert reset at cycle 2 of a DIV -> outputs 0 immediately; after release, IDLE with stall_count=0.
REQ-039 Saturation: preload 16'hFFFE, two stall cycles -> stall_count=16'hFFFF; then stat_clr=1 with pc_hold=1 -> stall_count=0.
